// File: rtl/otter_fetch_unit_pkg.sv
// Shared types for the OTTER fetch front end: queue entry layout and the
// request-tracking state of the fetch engine.
package otter_fetch_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] ir;
  } fetch_entry_t;

  // FS_PEND: request outstanding; FS_DROP: outstanding response is stale
  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_PEND = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/otter_sync_fifo.sv
// Single-clock first-word-fall-through queue; head entry reads as zero when
// empty and clear takes priority over push and pop.
module otter_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       clear,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count_reg != '0);

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[tail_reg] <= push_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N || clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) begin
        tail_reg <= tail_reg + AW'(1);
      end
      if (do_pop) begin
        head_reg <= head_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CW'(DEPTH));
  assign count     = count_reg;
  assign head_data = empty ? '0 : mem[head_reg];

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RESET_N)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/otter_fetch_unit.sv
// Instruction-fetch front end: issues word requests over req/ack, queues
// {pc, ir} pairs for decode and handles redirects with stale-response drop.
module otter_fetch_unit
  import otter_fetch_unit_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter int               DEPTH     = 4,
  parameter logic [XLEN-1:0]  RESET_VEC = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [XLEN-1:0] IMEM_RDATA,
  input  logic            REDIRECT,
  input  logic [XLEN-1:0] REDIRECT_PC,
  output logic            IF_VALID,
  input  logic            IF_READY,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_IR
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t    state_reg;
  fetch_state_t    state_next;
  logic [XLEN-1:0] fetch_pc_reg;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] req_addr_reg;
  logic [XLEN-1:0] redirect_target;
  logic            redirect_lsb_unused;

  logic            pending;
  logic            drop;
  logic            imem_fire;
  logic            push;
  logic            pop;
  logic            slot_free;
  logic [CW:0]     occupancy;

  logic [2*XLEN-1:0] push_data;
  logic [2*XLEN-1:0] head_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign pending = (state_reg != FS_IDLE);
  assign drop    = (state_reg == FS_DROP);

  assign redirect_target     = {REDIRECT_PC[XLEN-1:2], 2'b00};
  assign redirect_lsb_unused = |REDIRECT_PC[1:0];

  // A new request needs a queue slot reserved for its response
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, pending};
  assign slot_free = (occupancy < (CW+1)'(DEPTH));

  assign IMEM_REQ  = RESET_N && (pending || slot_free);
  assign IMEM_ADDR = pending ? req_addr_reg : fetch_pc_reg;
  assign imem_fire = IMEM_REQ && IMEM_ACK;

  assign push      = imem_fire && !drop && !REDIRECT;
  assign pop       = IF_VALID && IF_READY && !REDIRECT;
  assign push_data = {IMEM_ADDR, IMEM_RDATA};

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    case (state_reg)
      FS_IDLE: begin
        if (IMEM_REQ && !IMEM_ACK) begin
          state_next = REDIRECT ? FS_DROP : FS_PEND;
        end
      end
      FS_PEND: begin
        if (imem_fire) begin
          state_next = FS_IDLE;
        end else if (REDIRECT) begin
          state_next = FS_DROP;
        end
      end
      FS_DROP: begin
        if (imem_fire) begin
          state_next = FS_IDLE;
        end
      end
      default: state_next = FS_IDLE;
    endcase

    // Redirect target outranks the sequential successor of any response
    if (REDIRECT) begin
      fetch_pc_next = redirect_target;
    end else if (imem_fire && !drop) begin
      fetch_pc_next = IMEM_ADDR + XLEN'(4);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_reg    <= FS_IDLE;
      fetch_pc_reg <= RESET_VEC;
      req_addr_reg <= RESET_VEC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (state_reg == FS_IDLE) begin
        req_addr_reg <= fetch_pc_reg;
      end
    end
  end

  otter_sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (REDIRECT),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign IF_VALID = !fifo_empty;
  assign IF_PC    = head_data[2*XLEN-1:XLEN];
  assign IF_IR    = head_data[XLEN-1:0];

  a_reserved_slot: assert property (@(posedge CLK) disable iff (!RESET_N)
    pending |-> !fifo_full);

endmodule
